bcd_sseg_scanner: RTL and testbench

Time-multiplexed four-digit seven-segment driver. Consumes the 16-bit packed-BCD word from the binary-to-BCD stage, holds it in a capture register, and scans it onto a common-anode four-digit display with optional leading-zero blanking and per-digit decimal points. Sits directly downstream of the BCD converter, at the top-level display pins.

---
 rtl/sseg_pkg.sv | 30 +++
 rtl/bcd_to_sseg.sv | 27 ++
 rtl/bcd_sseg_scanner.sv | 101 ++++++++++
 tb/tb_bcd_sseg_scanner.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions for the display path.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low (0 = lit).
package sseg_pkg;

  // Bit positions within a segment vector.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Digit glyphs 0-9.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // Invalid BCD shows a lone middle bar; a blanked digit is fully dark.
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD nibble to active-low seven-segment pattern.
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup; anything above 9 is not BCD and shows a dash.
  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_sseg_scanner.sv
// Four-digit common-anode seven-segment scanner with leading-zero blanking.
// Captures a packed-BCD word and round-robins digits 0..3, each lit for
// DIGIT_CYCLES clocks. All outputs are registered (one cycle of latency).
module bcd_sseg_scanner
  import sseg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [15:0]      val_q;
  logic [3:0]       dp_q;

  logic             cnt_wrap;
  logic [3:0]       blank_mask;
  logic [3:0]       cur_nibble;
  logic             cur_blank;
  logic [6:0]       dec_seg;

  assign cnt_wrap = (cnt_q == CNT_MAX);

  // Digit i blanks only if it and every more-significant nibble are zero.
  always_comb begin
    blank_mask    = 4'b0000;
    blank_mask[3] = blank_lz && (val_q[15:12] == 4'd0);
    blank_mask[2] = blank_mask[3] && (val_q[11:8] == 4'd0);
    blank_mask[1] = blank_mask[2] && (val_q[7:4] == 4'd0);
    blank_mask[0] = 1'b0;
  end

  // Select the nibble for the digit currently being scanned.
  always_comb begin
    cur_nibble = val_q[3:0];
    case (idx_q)
      2'd0: cur_nibble = val_q[3:0];
      2'd1: cur_nibble = val_q[7:4];
      2'd2: cur_nibble = val_q[11:8];
      2'd3: cur_nibble = val_q[15:12];
      default: cur_nibble = val_q[3:0];
    endcase
  end

  assign cur_blank = blank_mask[idx_q];

  bcd_to_sseg u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // Tick counter and digit index; the index steps as the counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else if (cnt_wrap) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Capture register for the displayed value and its decimal points.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= 16'h0000;
      dp_q  <= 4'b0000;
    end else if (load) begin
      val_q <= bcd_in;
      dp_q  <= dp_in;
    end
  end

  // Output registers; reset leaves the display dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx_q);
      seg <= cur_blank ? SEG_BLANK : dec_seg;
      dp  <= cur_blank ? 1'b1 : ~dp_q[idx_q];
    end
  end

endmodule

// File: tb/tb_bcd_sseg_scanner.sv
// Directed self-checking bench for bcd_sseg_scanner with DIGIT_CYCLES = 4.
module tb_bcd_sseg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [6:0] seg_seen [4];
  logic       dp_seen  [4];

  bcd_sseg_scanner #(
    .DIGIT_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .load     (load),
    .blank_lz (blank_lz),
    .dp_in    (dp_in),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one full scan (16 cycles) and record what each digit shows.
  task automatic scan_capture();
    for (int d = 0; d < 4; d++) begin
      seg_seen[d] = 7'h55;
      dp_seen[d]  = 1'bx;
    end
    for (int c = 0; c < 16; c++) begin
      step();
      case (an)
        4'b1110: begin seg_seen[0] = seg; dp_seen[0] = dp; end
        4'b1101: begin seg_seen[1] = seg; dp_seen[1] = dp; end
        4'b1011: begin seg_seen[2] = seg; dp_seen[2] = dp; end
        4'b0111: begin seg_seen[3] = seg; dp_seen[3] = dp; end
        default: check("an_onehot", {12'h0, an}, 16'h000e);
      endcase
    end
  endtask

  // Load a value, then wait one extra edge so outputs reflect it.
  task automatic load_value(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v;
    dp_in  = d;
    load   = 1'b1;
    step();
    load   = 1'b0;
    step();
  endtask

  initial begin
    rst      = 1'b1;
    bcd_in   = 16'h0000;
    load     = 1'b0;
    blank_lz = 1'b0;
    dp_in    = 4'b0000;

    // 1. Reset and scan order.
    repeat (3) step();
    check("rst_an",  {12'h0, an},  16'h000f);
    check("rst_seg", {9'h0, seg},  16'h007f);
    check("rst_dp",  {15'h0, dp},  16'h0001);
    rst = 1'b0;
    step();
    check("first_an",  {12'h0, an}, 16'h000e);
    check("first_seg", {9'h0, seg}, 16'h0040);
    repeat (3) step();
    check("dig0_hold_an", {12'h0, an}, 16'h000e);
    step();
    check("scan_an1", {12'h0, an}, 16'h000d);
    repeat (4) step();
    check("scan_an2", {12'h0, an}, 16'h000b);
    repeat (4) step();
    check("scan_an3", {12'h0, an}, 16'h0007);
    repeat (4) step();
    check("scan_an0", {12'h0, an}, 16'h000e);

    // 2. Leading-zero blanking on.
    blank_lz = 1'b1;
    load_value(16'h0255, 4'b0000);
    scan_capture();
    check("blk_d0", {9'h0, seg_seen[0]}, 16'h0012);
    check("blk_d1", {9'h0, seg_seen[1]}, 16'h0012);
    check("blk_d2", {9'h0, seg_seen[2]}, 16'h0024);
    check("blk_d3", {9'h0, seg_seen[3]}, 16'h007f);

    // 3a. Blanking off, same captured value (blank_lz is live).
    blank_lz = 1'b0;
    step();
    scan_capture();
    check("noblk_d3", {9'h0, seg_seen[3]}, 16'h0040);
    check("noblk_d2", {9'h0, seg_seen[2]}, 16'h0024);

    // 3b. All zeros with blanking: only digit 0 lit.
    blank_lz = 1'b1;
    load_value(16'h0000, 4'b0000);
    scan_capture();
    check("zero_d0", {9'h0, seg_seen[0]}, 16'h0040);
    check("zero_d1", {9'h0, seg_seen[1]}, 16'h007f);
    check("zero_d2", {9'h0, seg_seen[2]}, 16'h007f);
    check("zero_d3", {9'h0, seg_seen[3]}, 16'h007f);

    // 3c. Blanked digit forces its dp off.
    load_value(16'h0007, 4'b1010);
    scan_capture();
    check("blkdp_d1", {15'h0, dp_seen[1]}, 16'h0001);
    check("blkdp_d3", {15'h0, dp_seen[3]}, 16'h0001);
    check("blkdp_d0", {9'h0, seg_seen[0]}, 16'h0078);

    // 4. Invalid BCD and decimal point.
    blank_lz = 1'b0;
    load_value(16'h00a0, 4'b0010);
    scan_capture();
    check("inv_d1_seg", {9'h0, seg_seen[1]}, 16'h003f);
    check("inv_d1_dp",  {15'h0, dp_seen[1]}, 16'h0000);
    check("inv_d0_seg", {9'h0, seg_seen[0]}, 16'h0040);
    check("inv_d0_dp",  {15'h0, dp_seen[0]}, 16'h0001);
    check("inv_d2_dp",  {15'h0, dp_seen[2]}, 16'h0001);
    check("inv_d3_dp",  {15'h0, dp_seen[3]}, 16'h0001);

    // 5. Load coinciding with a digit advance, then reset mid-digit.
    rst = 1'b1;
    step();
    rst    = 1'b0;
    bcd_in = 16'h1234;
    dp_in  = 4'b0000;
    load   = 1'b1;
    step();                       // edge1: cnt 0->1
    load = 1'b0;
    step();                       // edge2
    step();                       // edge3: cnt now 3, idx 0
    bcd_in = 16'h2047;
    load   = 1'b1;
    step();                       // edge4: advance and load together
    load = 1'b0;
    check("sim_old_an",  {12'h0, an}, 16'h000e);
    check("sim_old_seg", {9'h0, seg}, 16'h0019);
    step();                       // edge5: new value at new index
    check("sim_new_an",  {12'h0, an}, 16'h000d);
    check("sim_new_seg", {9'h0, seg}, 16'h0019);
    check("sim_new_dp",  {15'h0, dp}, 16'h0001);
    step();
    rst = 1'b1;
    step();
    check("midrst_an",  {12'h0, an}, 16'h000f);
    check("midrst_seg", {9'h0, seg}, 16'h007f);
    check("midrst_dp",  {15'h0, dp}, 16'h0001);
    rst = 1'b0;
    step();
    check("restart_an",  {12'h0, an}, 16'h000e);
    check("restart_seg", {9'h0, seg}, 16'h0040);
    repeat (3) step();
    check("restart_hold", {12'h0, an}, 16'h000e);
    step();
    check("restart_adv", {12'h0, an}, 16'h000d);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
